// File: rtl/set_host.sv
// rtl/set_host.sv - SET test host: fetches ROM patterns, issues SET requests, checks results
// Watchdog guards both wait states; a run ends on last pattern, MAX_ERR mismatches or timeout.
module set_host #(
  parameter int NPAT_MAX = 64,
  parameter int MAX_ERR  = 10,
  parameter int TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode_sel,
  input  logic [6:0]  num_pat,
  output logic [5:0]  pat_addr,
  input  logic [23:0] pat_central,
  input  logic [11:0] pat_radius,
  input  logic [7:0]  pat_expected,
  output logic        en,
  output logic [23:0] central,
  output logic [11:0] radius,
  output logic [1:0]  mode,
  input  logic        busy,
  input  logic        valid,
  input  logic [7:0]  candidate,
  output logic        running,
  output logic        done,
  output logic [6:0]  err_cnt,
  output logic [5:0]  first_fail_idx,
  output logic        timeout,
  output logic        aborted
);

  localparam logic [6:0]  NPAT_C  = 7'(NPAT_MAX);
  localparam logic [6:0]  MAXE_C  = 7'(MAX_ERR);
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT_BUSY, S_ISSUE, S_WAIT_VALID, S_CHECK, S_DONE
  } state_t;

  state_t      state, next;
  logic [6:0]  count;
  logic [6:0]  clip_num;
  logic [7:0]  exp_reg;
  logic [7:0]  cand_reg;
  logic [11:0] wdog;
  logic [6:0]  err_next;
  logic        mismatch;
  logic        last_pat;
  logic        wd_expired;
  logic        to_fire;
  logic        abort_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next       = state;
    en         = 1'b0;
    to_fire    = 1'b0;
    abort_err  = 1'b0;
    mismatch   = (cand_reg != exp_reg);
    err_next   = (mismatch && err_cnt != MAXE_C) ? err_cnt + 7'd1 : err_cnt;
    last_pat   = ({1'b0, pat_addr} == count - 7'd1);
    wd_expired = (wdog == TO_LAST);
    clip_num   = (num_pat == 7'd0) ? 7'd1 : (num_pat > NPAT_C) ? NPAT_C : num_pat;
    case (state)
      S_IDLE:      if (start) next = S_FETCH;
      S_FETCH:     next = S_LOAD;
      S_LOAD:      next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!busy) next = S_ISSUE;
        else if (wd_expired) begin
          next    = S_DONE;
          to_fire = 1'b1;
        end
      end
      S_ISSUE: begin
        en   = 1'b1;
        next = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (valid) next = S_CHECK;
        else if (wd_expired) begin
          next    = S_DONE;
          to_fire = 1'b1;
        end
      end
      S_CHECK: begin
        if (err_next == MAXE_C) begin
          next      = S_DONE;
          abort_err = 1'b1;
        end else if (last_pat) next = S_DONE;
        else                   next = S_FETCH;
      end
      S_DONE:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode           <= '0;
      count          <= '0;
      pat_addr       <= '0;
      central        <= '0;
      radius         <= '0;
      exp_reg        <= '0;
      cand_reg       <= '0;
      err_cnt        <= '0;
      first_fail_idx <= '0;
      timeout        <= 1'b0;
      aborted        <= 1'b0;
      running        <= 1'b0;
      done           <= 1'b0;
      wdog           <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode           <= mode_sel;
          count          <= clip_num;
          pat_addr       <= '0;
          err_cnt        <= '0;
          first_fail_idx <= '0;
          timeout        <= 1'b0;
          aborted        <= 1'b0;
          done           <= 1'b0;
          running        <= 1'b1;
        end
        S_LOAD: begin
          central <= pat_central;
          radius  <= pat_radius;
          exp_reg <= pat_expected;
        end
        S_WAIT_VALID: if (valid) cand_reg <= candidate;
        S_CHECK: begin
          err_cnt <= err_next;
          if (mismatch && err_cnt == 7'd0) first_fail_idx <= pat_addr;
          if (abort_err) aborted <= 1'b1;
          if (next == S_FETCH) pat_addr <= pat_addr + 6'd1;
        end
        default: ;
      endcase
      if (to_fire) begin
        timeout <= 1'b1;
        aborted <= 1'b1;
      end
      if (next == S_DONE) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
      // Held at zero outside the wait states, so it starts from zero on every entry.
      if ((state == S_WAIT_BUSY || state == S_WAIT_VALID) && next == state)
        wdog <= wdog + 12'd1;
      else
        wdog <= '0;
    end
  end

endmodule

// File: tb/tb_set_host.sv
// tb/tb_set_host.sv - scoreboard bench for set_host with ROM and SET engine models
module tb_set_host;
  localparam int TIMEOUT = 4095;
  localparam int MAX_ERR = 10;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0]  mode_sel = '0;
  logic [6:0]  num_pat = '0;
  logic [5:0]  pat_addr;
  logic [23:0] pat_central = '0;
  logic [11:0] pat_radius = '0;
  logic [7:0]  pat_expected = '0;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy = 1'b0, valid = 1'b0;
  logic [7:0]  candidate = '0;
  logic        running, done, timeout, aborted;
  logic [6:0]  err_cnt;
  logic [5:0]  first_fail_idx;

  set_host dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel), .num_pat(num_pat),
    .pat_addr(pat_addr), .pat_central(pat_central), .pat_radius(pat_radius),
    .pat_expected(pat_expected), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate),
    .running(running), .done(done), .err_cnt(err_cnt), .first_fail_idx(first_fail_idx),
    .timeout(timeout), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [23:0] rom_c[64];
  logic [11:0] rom_r[64];
  logic [7:0]  rom_e[64];

  always @(posedge clk) begin
    pat_central  <= rom_c[pat_addr];
    pat_radius   <= rom_r[pat_addr];
    pat_expected <= rom_e[pat_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          exp_q[$];
  int          cur_idx = 0;
  int          cnt = 0;
  int          busy_len = 5;
  logic        hold_busy = 1'b0, hold_prev = 1'b0, respond = 1'b1;
  logic [63:0] bad_mask = '0;
  logic [1:0]  run_mode = '0;
  int          en_count = 0, last_en_cyc = 0, first_en_cyc = -1, hold_fall_cyc = 0;

  // SET engine: busy for busy_len cycles after each request, then a one-cycle valid.
  always @(negedge clk) begin
    valid = 1'b0;
    if (!rst) begin
      cnt  = 0;
      busy = 1'b0;
    end else begin
      if (en) begin
        en_count++;
        last_en_cyc = cyc;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        chk("busy_at_en", 64'(busy), 64'(0));
        chk("en_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          cur_idx = exp_q.pop_front();
          chk("central", 64'(central), 64'(rom_c[cur_idx]));
          chk("radius", 64'(radius), 64'(rom_r[cur_idx]));
          chk("mode", 64'(mode), 64'(run_mode));
        end
        cnt = busy_len;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && respond) begin
          valid     = 1'b1;
          candidate = rom_e[cur_idx] ^ (bad_mask[cur_idx] ? 8'h5A : 8'h00);
          chk("central_stable", 64'(central), 64'(rom_c[cur_idx]));
        end
      end
      if (hold_prev && !hold_busy) hold_fall_cyc = cyc;
      hold_prev = hold_busy;
      busy = hold_busy || (cnt > 0);
    end
  end

  int          exp_err, exp_ffi, exp_last;
  logic        exp_abort, exp_to;

  task automatic launch(input int num, input logic [1:0] m, input int blen, input logic [63:0] bad);
    int n;
    n = (num == 0) ? 1 : (num > 64) ? 64 : num;
    exp_err = 0; exp_ffi = 0; exp_last = 0; exp_abort = 1'b0; exp_to = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(i);
      exp_last = i;
      if (bad[i]) begin
        if (exp_err == 0) exp_ffi = i;
        exp_err++;
        if (exp_err == MAX_ERR) begin
          exp_abort = 1'b1;
          break;
        end
      end
    end
    busy_len = blen; bad_mask = bad; run_mode = m; en_count = 0;
    @(negedge clk);
    start = 1'b1; num_pat = num[6:0]; mode_sel = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  task automatic check_result();
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("first_fail_idx", 64'(first_fail_idx), 64'(exp_ffi));
    chk("aborted", 64'(aborted), 64'(exp_abort));
    chk("timeout", 64'(timeout), 64'(exp_to));
    chk("running", 64'(running), 64'(0));
    chk("pat_addr", 64'(pat_addr), 64'(exp_last));
    chk("pending_issues", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_c[i] = 24'($urandom);
      rom_r[i] = 12'($urandom);
      rom_e[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("rst_status", 64'({en, running, done, timeout, aborted, pat_addr, err_cnt, first_fail_idx}), 64'(0));
    chk("rst_operands", 64'({central, radius, mode}), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    launch(3, 2'd1, 5, 64'h0);
    wait_done();
    chk("en_count_3", 64'(en_count), 64'(3));
    check_result();

    launch(4, 2'd2, 3, 64'h4);
    wait_done();
    chk("en_count_4", 64'(en_count), 64'(4));
    check_result();

    launch(64, 2'd3, 1, '1);
    wait_done();
    chk("en_count_abort", 64'(en_count), 64'(10));
    check_result();

    respond = 1'b0;
    launch(1, 2'd0, 2, 64'h0);
    exp_to = 1'b1; exp_abort = 1'b1;
    begin
      int k = 0;
      while (!timeout && k < TIMEOUT + 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("timeout_cycle", 64'(cyc), 64'(last_en_cyc + 1 + TIMEOUT));
    wait_done();
    check_result();
    respond = 1'b1;

    hold_busy = 1'b1;
    first_en_cyc = -1;
    launch(2, 2'd1, 2, 64'h0);
    repeat (8) @(negedge clk);
    start = 1'b1; num_pat = 7'd5; mode_sel = 2'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 hold_busy = 1'b0;
    wait_done();
    chk("en_after_busy", 64'(first_en_cyc), 64'(hold_fall_cyc + 1));
    chk("en_count_hold", 64'(en_count), 64'(2));
    check_result();

    launch(100, 2'd3, 1, 64'h0);
    wait_done();
    chk("en_count_clip", 64'(en_count), 64'(64));
    check_result();

    launch(3, 2'd2, 6, 64'h0);
    begin
      int k = 0;
      while (en_count == 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_rst_status", 64'({en, running, done, timeout, aborted, pat_addr, err_cnt, first_fail_idx}), 64'(0));
    chk("midrun_rst_operands", 64'({central, radius, mode}), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_en_after_rst", 64'(en_count), 64'(1));
    launch(0, 2'd1, 2, 64'h0);
    wait_done();
    chk("en_count_zero", 64'(en_count), 64'(1));
    check_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/set_host.md
SET_HOST -- requirements
Module: set_host

Interface
REQ-001 Parameter NPAT_MAX, default 64, maximum pattern count per run.
REQ-002 Parameter MAX_ERR, default 10, mismatch count that aborts a run.
REQ-003 Parameter TIMEOUT, default 4095, cycles allowed per wait state before abort.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  one-cycle pulse to launch a run; ignored unless IDLE.
REQ-007 mode_sel  input  2  SET mode for the run (00..11).
REQ-008 num_pat  input  7  patterns to run, 1..64; 0 treated as 1, values >64 as 64.
REQ-009 pat_addr  output  6  pattern ROM address.
REQ-010 pat_central / pat_radius / pat_expected  input  24 / 12 / 8  ROM data, valid one cycle after pat_addr changes.
REQ-011 en  output  1  SET request strobe.
REQ-012 central / radius / mode  output  24 / 12 / 2  SET operands.
REQ-013 busy  input  1  SET busy.
REQ-014 valid  input  1  SET result strobe.
REQ-015 candidate  input  8  SET result.
REQ-016 running / done  output  1 / 1  run in progress / run finished (level, cleared by next start).
REQ-017 err_cnt  output  7  mismatches in current run.
REQ-018 first_fail_idx  output  6  index of first mismatch; meaningful only when err_cnt != 0.
REQ-019 timeout / aborted  output  1 / 1  watchdog fired / run stopped early.

Function
REQ-020 FSM states: IDLE, FETCH, LOAD, WAIT_BUSY, ISSUE, WAIT_VALID, CHECK, DONE.
REQ-021 IDLE: on start, latch mode_sel into mode, latch clipped num_pat, set pat_addr=0, clear err_cnt/timeout/aborted/done, set running=1, go to FETCH.
REQ-022 FETCH: one wait cycle for ROM latency, go to LOAD.
REQ-023 LOAD: register pat_central->central, pat_radius->radius, pat_expected->internal exp_reg; go to WAIT_BUSY.
REQ-024 WAIT_BUSY: remain while busy==1; when busy==0, go to ISSUE.
REQ-025 ISSUE: en=1 for exactly one cycle; go to WAIT_VALID.
REQ-026 central, radius and mode shall be stable from LOAD until valid is sampled high.
REQ-027 WAIT_VALID: on the first cycle with valid==1, capture candidate into cand_reg and go to CHECK; valid coinciding with the ISSUE cycle is ignored.
REQ-028 CHECK: if cand_reg != exp_reg, increment err_cnt; on the first mismatch also load first_fail_idx=pat_addr.
REQ-029 CHECK exit: if err_cnt (after update) == MAX_ERR, set aborted=1 and go to DONE; else if pat_addr == count-1, go to DONE; else increment pat_addr and go to FETCH.
REQ-030 Watchdog: a 12-bit counter clears on entry to WAIT_BUSY or WAIT_VALID and increments while in either; reaching TIMEOUT sets timeout=1, aborted=1, and goes to DONE.
REQ-031 DONE: running=0, done=1, en=0; go to IDLE next cycle; done, err_cnt, first_fail_idx, timeout and aborted hold until the next start.
REQ-032 start while not IDLE shall have no effect.
REQ-033 err_cnt saturates at MAX_ERR; pat_addr never exceeds count-1 and does not wrap.
REQ-034 en shall never be asserted while busy==1 was sampled in the same cycle's WAIT_BUSY decision.

Reset
REQ-035 While rst==0: state=IDLE; en, central, radius, mode, pat_addr, running, done, err_cnt, first_fail_idx, timeout, aborted all 0; internal registers 0.
REQ-036 Reset assertion mid-run aborts immediately without setting done; no en pulse follows reset release until a new start.

Verification
REQ-037 num_pat=3, model SET busy 5 cycles and returns expected -> three single-cycle en pulses, done=1, err_cnt=0, aborted=0.
REQ-038 num_pat=4, pattern 2 returns wrong candidate -> err_cnt=1, first_fail_idx=2, all 4 patterns issued, done=1.
REQ-039 num_pat=64, every result wrong -> aborted=1 after 10th check, err_cnt=10, pat_addr=9, no 11th en pulse.
REQ-040 SET never raises valid -> timeout=1, aborted=1 exactly TIMEOUT cycles after WAIT_VALID entry.
REQ-041 busy held high 20 cycles before pattern 0 -> en asserted in the cycle after busy falls; start pulsed mid-run ignored.
REQ-042 rst driven low during WAIT_VALID -> all outputs 0 immediately; after release a new start with num_pat=0 runs exactly one pattern.
